// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counting timer: FSM state
// encoding, register word offsets, CTRL bit positions and MODE codes.
package timer_counter_pkg;

  // FSM state encoding (2-bit)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Register word offsets (PrAddr[3:2])
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  // MODE codes; the two unlisted codes fall back to one-shot
  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_AUTO    = 2'b01
  } mode_e;

  function automatic logic is_auto_reload(input logic [1:0] mode);
    return (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit down-counting timer behind the system bridge. CTRL/PRESET are
// bus-writable, COUNT is read-only, IRQ = IM & irq_flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped; waits for EN, COUNT holds its last value
// LOAD  | copies PRESET into COUNT on the way out
// CNT   | decrements COUNT while EN; reaching <=1 sets irq_flag -> INT
// INT   | one-shot: clear EN, back to IDLE; auto-reload: clear flag, LOAD
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [31:0]       preset_q;
  logic [31:0]       count_q;
  logic [1:0]        state_q;
  logic              irq_flag_q;

  logic [1:0]        state_d;
  logic [31:0]       count_d;
  logic              irq_set;
  logic              irq_clr_hw;
  logic              en_clr_hw;

  logic              wr_ctrl;
  logic              wr_preset;
  logic              ctrl_en;
  logic [1:0]        ctrl_mode;

  // Upper CTRL write bits are architecturally ignored.
  logic              unused_din_hi;
  assign unused_din_hi = ^Din[31:CTRL_W];

  assign wr_ctrl   = WE && (Addr == OFF_CTRL);
  assign wr_preset = WE && (Addr == OFF_PRESET);
  assign ctrl_en   = ctrl_q[CTRL_EN];
  assign ctrl_mode = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

  // Next-state and COUNT update, decided from pre-write register values
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    irq_set    = 1'b0;
    irq_clr_hw = 1'b0;
    en_clr_hw  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET of 0 lands here too, so it behaves like PRESET of 1
          count_d = 32'd0;
          irq_set = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (is_auto_reload(ctrl_mode)) begin
          irq_clr_hw = 1'b1;
          state_d    = ST_LOAD;
        end else begin
          en_clr_hw = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // COUNT register; bus writes to it are ignored
  always_ff @(posedge clk) begin
    if (reset) count_q <= 32'd0;
    else       count_q <= count_d;
  end

  // CTRL register; a bus write wins over the one-shot EN clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
    end else if (wr_ctrl) begin
      ctrl_q <= Din[CTRL_W-1:0];
    end else if (en_clr_hw) begin
      ctrl_q[CTRL_EN] <= 1'b0;
    end
  end

  // PRESET register
  always_ff @(posedge clk) begin
    if (reset)          preset_q <= 32'd0;
    else if (wr_preset) preset_q <= Din;
  end

  // irq_flag: expiry set beats any clear on the same edge
  always_ff @(posedge clk) begin
    if (reset)                                   irq_flag_q <= 1'b0;
    else if (irq_set)                            irq_flag_q <= 1'b1;
    else if (wr_ctrl || wr_preset || irq_clr_hw) irq_flag_q <= 1'b0;
  end

  assign IRQ = ctrl_q[CTRL_IM] & irq_flag_q;

  // Combinational read mux
  always_comb begin
    Dout = 32'd0;
    case (Addr)
      OFF_CTRL:   Dout = {{(32-CTRL_W){1'b0}}, ctrl_q};
      OFF_PRESET: Dout = preset_q;
      OFF_COUNT:  Dout = count_q;
      OFF_RSVD:   Dout = 32'd0;
      default:    Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one bus write; returns 1ns after the write edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input string tag, input logic [31:0] exp);
    Addr = a;
    #1;
    check(tag, Dout, exp);
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    check(tag, {31'd0, IRQ}, {31'd0, exp});
  endtask

  initial begin
    // reset with a write attempt during it
    reset = 1'b1;
    WE    = 1'b1;
    Addr  = 2'd1;
    Din   = 32'hDEAD_BEEF;
    tick();
    Addr  = 2'd0;
    Din   = 32'h0000_000F;
    tick();
    WE    = 1'b0;
    reset = 1'b0;
    rd_chk(2'd0, "rst_ctrl", 32'd0);
    rd_chk(2'd1, "rst_preset", 32'd0);
    rd_chk(2'd2, "rst_count", 32'd0);
    rd_chk(2'd3, "rst_rsvd", 32'd0);
    irq_chk("rst_irq", 1'b0);
    tick();
    rd_chk(2'd2, "rst_count_idle", 32'd0);

    // one-shot, PRESET=5
    wr(2'd1, 32'd5);
    rd_chk(2'd1, "os_preset", 32'd5);
    wr(2'd0, 32'h9);                  // E0
    irq_chk("os_irq_e0", 1'b0);
    tick();                           // E1: LOAD
    rd_chk(2'd2, "os_count_e1", 32'd0);
    tick();                           // E2
    for (int k = 0; k <= 5; k++) begin
      rd_chk(2'd2, $sformatf("os_count_e%0d", k + 2), 32'(5 - k));
      irq_chk($sformatf("os_irq_e%0d", k + 2), (k == 5));
      if (k < 5) tick();
    end
    tick();                           // E8: IDLE, EN cleared
    rd_chk(2'd0, "os_ctrl_e8", 32'h8);
    irq_chk("os_irq_e8", 1'b1);
    tick();
    tick();
    irq_chk("os_irq_held", 1'b1);
    rd_chk(2'd2, "os_count_held", 32'd0);
    wr(2'd0, 32'h0);
    irq_chk("os_irq_clr", 1'b0);

    // auto-reload, PRESET=3: period 5, INT at E5, E10, ...
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);                  // E0
    for (int k = 1; k <= 22; k++) begin
      logic [31:0] exp_cnt;
      logic        exp_irq;
      int          q;
      tick();
      q = (k - 2) % 5;
      if (k == 1)      exp_cnt = 32'd0;
      else if (q == 0) exp_cnt = 32'd3;
      else if (q == 1) exp_cnt = 32'd2;
      else if (q == 2) exp_cnt = 32'd1;
      else             exp_cnt = 32'd0;
      exp_irq = (k >= 2) && (q == 3);
      rd_chk(2'd2, $sformatf("ar_count_e%0d", k), exp_cnt);
      irq_chk($sformatf("ar_irq_e%0d", k), exp_irq);
    end
    wr(2'd0, 32'h0);                  // still counts this edge: 3 -> 2
    tick();                           // IDLE, frozen
    tick();
    rd_chk(2'd2, "ar_stop_count", 32'd2);
    irq_chk("ar_stop_irq", 1'b0);

    // mask: IM=0, flag sets silently
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);                  // E0
    tick(); tick(); tick(); tick();   // E4: INT
    rd_chk(2'd2, "mask_count_int", 32'd0);
    irq_chk("mask_irq_int", 1'b0);
    tick();                           // E5: IDLE, EN cleared
    rd_chk(2'd0, "mask_ctrl", 32'h0);
    wr(2'd0, 32'h9);                  // clears flag, restarts
    irq_chk("mask_irq_after_wr", 1'b0);
    tick(); tick(); tick();           // LOAD, 2, 1
    irq_chk("mask_irq_pre", 1'b0);
    tick();                           // INT
    irq_chk("mask_irq_rearm", 1'b1);
    tick();
    wr(2'd0, 32'h0);
    irq_chk("mask_irq_clr", 1'b0);

    // pause and update
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);                  // E0
    tick(); tick(); tick(); tick(); tick();  // E5: COUNT=7
    rd_chk(2'd2, "pause_count7", 32'd7);
    wr(2'd0, 32'h8);                  // 7 -> 6, EN now 0
    tick();                           // IDLE
    rd_chk(2'd2, "pause_count_frozen", 32'd6);
    tick();
    rd_chk(2'd2, "pause_count_frozen2", 32'd6);
    wr(2'd1, 32'd2);
    rd_chk(2'd2, "pause_preset_wr", 32'd6);
    rd_chk(2'd1, "pause_preset_rd", 32'd2);
    wr(2'd0, 32'h9);
    tick();                           // LOAD
    rd_chk(2'd2, "pause_in_load", 32'd6);
    tick();                           // CNT, COUNT=PRESET
    rd_chk(2'd2, "pause_reload", 32'd2);
    wr(2'd0, 32'h0);
    tick();
    irq_chk("pause_irq", 1'b0);

    // same-edge set wins; CTRL write in INT beats EN clear
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);                  // E0
    tick(); tick();                   // E2: COUNT=1
    wr(2'd1, 32'd1);                  // E3: INT, set wins
    irq_chk("race_set_wins", 1'b1);
    wr(2'd0, 32'h9);                  // E4: write in INT
    rd_chk(2'd0, "race_ctrl_keeps_en", 32'h9);
    irq_chk("race_irq_cleared", 1'b0);
    wr(2'd0, 32'h0);
    tick(); tick();

    // PRESET = 0
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);                  // E0
    tick(); tick();                   // E2: CNT
    irq_chk("p0_irq_e2", 1'b0);
    tick();                           // E3: INT
    irq_chk("p0_irq_e3", 1'b1);
    rd_chk(2'd2, "p0_count", 32'd0);
    tick();
    wr(2'd0, 32'h0);

    // PRESET = max, no wrap
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h1);                  // E0
    tick(); tick();                   // E2
    rd_chk(2'd2, "pmax_load", 32'hFFFF_FFFF);
    tick();                           // E3
    rd_chk(2'd2, "pmax_dec", 32'hFFFF_FFFE);
    wr(2'd0, 32'h0);                  // E4: -> FFFFFFFD
    tick();                           // IDLE
    wr(2'd2, 32'h0000_0005);
    rd_chk(2'd2, "count_ro", 32'hFFFF_FFFD);
    wr(2'd3, 32'h1234_5678);
    rd_chk(2'd3, "rsvd_ro", 32'd0);
    rd_chk(2'd0, "rsvd_no_ctrl", 32'h0);

    // reset mid-count overrides a write
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    tick(); tick(); tick();
    reset = 1'b1;
    WE    = 1'b1;
    Addr  = 2'd0;
    Din   = 32'hF;
    tick();
    reset = 1'b0;
    WE    = 1'b0;
    rd_chk(2'd0, "mrst_ctrl", 32'd0);
    rd_chk(2'd1, "mrst_preset", 32'd0);
    rd_chk(2'd2, "mrst_count", 32'd0);
    irq_chk("mrst_irq", 1'b0);
    tick(); tick();
    rd_chk(2'd2, "mrst_idle", 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
